// File: rtl/spi_digit_pkg.sv
// Shared types and constants for the SPI digit command receiver.
package spi_digit_pkg;

    typedef enum logic [1:0] {
        OP_SET_DIGIT  = 2'b00,
        OP_SHOW_INSTR = 2'b01,
        OP_BLANK      = 2'b10,
        OP_RSVD       = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        CHECK
    } state_t;

    localparam int unsigned FRAME_BITS = 8;
    localparam logic [3:0]  MAX_DIGIT  = 4'd9;
    localparam logic [7:0]  RESET_ECHO = 8'h40;

endpackage

// File: rtl/spi_digit_ctrl_sync.sv
// Input synchronizer with registered edge pulses: SYNC_STAGES metastability flops,
// then a delayed level plus one-cycle rise/fall pulses aligned to that level.
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_last;
    logic                   r_rise;
    logic                   r_fall;

    // Resets low so an idle-high csN seen after reset reads as a rise, which IDLE ignores.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_last <= 1'b0;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_last <= r_sync[SYNC_STAGES-1];
            r_rise <= r_sync[SYNC_STAGES-1] & ~r_last;
            r_fall <= ~r_sync[SYNC_STAGES-1] & r_last;
        end
    end

    assign o_level = r_last;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/spi_digit_ctrl.sv
// SPI-slave command receiver feeding the VGA digit display: frame FSM, decode, hold timer.
// Optional read-back of the last accepted command on sdo when SPI_ECHO_EN is defined.
module spi_digit_ctrl
    import spi_digit_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] HOLD_CYCLES = 32'd400_000_000,
    parameter int unsigned HOLD_W      = 32
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sck,
    input  logic       sdi,
    input  logic       csN,
    output logic [3:0] digit,
    output logic       digitEn,
    output logic       instrEn,
    output logic       cmdErr
`ifdef SPI_ECHO_EN
   ,output logic       sdo
`endif
);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_CYCLES);
    localparam logic [3:0]        CNT_FULL  = 4'(FRAME_BITS);
    localparam logic [3:0]        CNT_SAT   = 4'(FRAME_BITS + 1);

    logic w_sck_level, w_sck_rise, w_sck_fall;
    logic w_sdi_level, w_sdi_rise, w_sdi_fall;
    logic w_cs_level,  w_cs_rise,  w_cs_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sck (
        .i_clk(clk), .i_rst_n(reset), .i_async(sck),
        .o_level(w_sck_level), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sdi (
        .i_clk(clk), .i_rst_n(reset), .i_async(sdi),
        .o_level(w_sdi_level), .o_rise(w_sdi_rise), .o_fall(w_sdi_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_cs (
        .i_clk(clk), .i_rst_n(reset), .i_async(csN),
        .o_level(w_cs_level), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    state_t            r_state, w_state_next;
    logic [7:0]        r_shift;
    logic [3:0]        r_bit_cnt;
    logic [3:0]        r_digit;
    logic              r_digit_en;
    logic              r_instr_en;
    logic              r_cmd_err;
    logic [HOLD_W-1:0] r_hold;
    opcode_t           w_opcode;
    logic              w_accept;
    logic              w_reject;

    always_ff @(posedge clk) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_cs_fall) w_state_next = SHIFT;
            SHIFT:   if (w_cs_rise) w_state_next = CHECK;
            CHECK:   w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == IDLE && w_cs_fall) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == SHIFT && w_sck_rise) begin
            r_shift <= {r_shift[6:0], w_sdi_level};
            if (r_bit_cnt != CNT_SAT) r_bit_cnt <= r_bit_cnt + 4'd1;
        end
    end

    always_comb begin
        w_opcode = opcode_t'(r_shift[7:6]);
        w_accept = 1'b0;
        w_reject = 1'b0;
        if (r_state == CHECK) begin
            if (r_bit_cnt != CNT_FULL) begin
                w_reject = 1'b1;
            end else begin
                case (w_opcode)
                    OP_SET_DIGIT: begin
                        if (r_shift[3:0] <= MAX_DIGIT) w_accept = 1'b1;
                        else                           w_reject = 1'b1;
                    end
                    OP_SHOW_INSTR, OP_BLANK: w_accept = 1'b1;
                    default:                 w_reject = 1'b1;
                endcase
            end
        end
    end

    // A commit takes priority over the hold timer reaching zero in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_digit    <= '0;
            r_digit_en <= 1'b0;
            r_instr_en <= 1'b1;
            r_cmd_err  <= 1'b0;
            r_hold     <= '0;
        end else begin
            r_cmd_err <= w_reject;
            if (w_accept) begin
                case (w_opcode)
                    OP_SET_DIGIT: begin
                        r_digit    <= r_shift[3:0];
                        r_digit_en <= 1'b1;
                        r_instr_en <= 1'b0;
                        r_hold     <= HOLD_LOAD;
                    end
                    OP_SHOW_INSTR: begin
                        r_digit_en <= 1'b0;
                        r_instr_en <= 1'b1;
                        r_hold     <= '0;
                    end
                    default: begin
                        r_digit_en <= 1'b0;
                        r_instr_en <= 1'b0;
                        r_hold     <= '0;
                    end
                endcase
            end else if (r_hold != '0) begin
                r_hold <= r_hold - HOLD_W'(1);
                if (r_hold == HOLD_W'(1)) begin
                    r_digit_en <= 1'b0;
                    r_instr_en <= 1'b1;
                end
            end
        end
    end

    assign digit   = r_digit;
    assign digitEn = r_digit_en;
    assign instrEn = r_instr_en;
    assign cmdErr  = r_cmd_err;

`ifdef SPI_ECHO_EN
    logic [7:0] r_echo;
    logic [7:0] r_tx;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_echo <= RESET_ECHO;
            r_tx   <= '0;
        end else begin
            if (w_accept) r_echo <= r_shift;
            if (r_state == IDLE && w_cs_fall)        r_tx <= r_echo;
            else if (r_state == SHIFT && w_sck_fall) r_tx <= {r_tx[6:0], 1'b0};
        end
    end

    assign sdo = r_tx[7];
`endif

    logic w_unused;
    assign w_unused = &{1'b0, w_sck_level, w_sck_fall, w_sdi_rise, w_sdi_fall, w_cs_level, r_shift[5:4]};

endmodule

// File: tb/tb_spi_digit_ctrl.sv
// Self-checking bench for spi_digit_ctrl: frame vector table with scoreboard, hold timer,
// reset mid-frame and (when SPI_ECHO_EN is defined) sdo read-back.
module tb_spi_digit_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sck = 1'b0;
    logic       sdi = 1'b0;
    logic       csN = 1'b1;
    logic [3:0] digit_a, digit_b;
    logic       den_a, den_b, ien_a, ien_b, err_a, err_b;
`ifdef SPI_ECHO_EN
    logic       sdo_a, sdo_b;
`endif

    int         total = 0;
    int         bad = 0;
    logic [15:0] echo_cap = '0;

    always #5 clk = ~clk;

    // dut_a: no timeout (HOLD_CYCLES 0); dut_b: 100-cycle hold. Both share the SPI pins.
    spi_digit_ctrl #(.SYNC_STAGES(2), .HOLD_CYCLES(32'd0), .HOLD_W(32)) dut_a (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .csN(csN),
        .digit(digit_a), .digitEn(den_a), .instrEn(ien_a), .cmdErr(err_a)
`ifdef SPI_ECHO_EN
       ,.sdo(sdo_a)
`endif
    );

    spi_digit_ctrl #(.SYNC_STAGES(2), .HOLD_CYCLES(32'd100), .HOLD_W(32)) dut_b (
        .clk(clk), .reset(reset), .sck(sck), .sdi(sdi), .csN(csN),
        .digit(digit_b), .digitEn(den_b), .instrEn(ien_b), .cmdErr(err_b)
`ifdef SPI_ECHO_EN
       ,.sdo(sdo_b)
`endif
    );

    typedef struct {
        logic [15:0] bits;
        int          n;
        logic [3:0]  digit;
        logic        den;
        logic        ien;
        logic        err;
    } vec_t;

    typedef struct {
        logic [3:0] digit;
        logic       den;
        logic       ien;
        logic       err;
    } exp_t;

    vec_t vecs[13];
    exp_t sb_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic sck_bit(input logic b);
        sdi = b;
        repeat (6) @(negedge clk);
`ifdef SPI_ECHO_EN
        echo_cap = {echo_cap[14:0], sdo_a};
`endif
        sck = 1'b1;
        repeat (6) @(negedge clk);
        sck = 1'b0;
    endtask

    task automatic send_bits(input logic [15:0] val, input int n);
        @(negedge clk);
        csN = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = n - 1; i >= 0; i--) sck_bit(val[i]);
        repeat (6) @(negedge clk);
        csN = 1'b1;
    endtask

    task automatic count_err(output int cnt);
        cnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (err_a === 1'b1) cnt++;
        end
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   errs;
        int   waited;
        logic stay_ok;
        exp_t e;

        vecs[0]  = '{16'h0007, 8, 4'd7, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{16'h000C, 8, 4'd7, 1'b1, 1'b0, 1'b1};
        vecs[2]  = '{16'h0035, 8, 4'd5, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{16'h0009, 8, 4'd9, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{16'h000A, 8, 4'd9, 1'b1, 1'b0, 1'b1};
        vecs[5]  = '{16'h0003, 5, 4'd9, 1'b1, 1'b0, 1'b1};
        vecs[6]  = '{16'h000E, 9, 4'd9, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{16'h0000, 0, 4'd9, 1'b1, 1'b0, 1'b1};
        vecs[8]  = '{16'h00C5, 8, 4'd9, 1'b1, 1'b0, 1'b1};
        vecs[9]  = '{16'h0080, 8, 4'd9, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{16'h0040, 8, 4'd9, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{16'h0000, 8, 4'd0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{16'h007F, 8, 4'd0, 1'b0, 1'b1, 1'b0};

        reset = 1'b0;
        repeat (4) @(negedge clk);
        check("rst_digit", 32'(digit_a), 32'd0);
        check("rst_digitEn", 32'(den_a), 32'd0);
        check("rst_instrEn", 32'(ien_a), 32'd1);
        check("rst_cmdErr", 32'(err_a), 32'd0);
        reset = 1'b1;
        repeat (10) @(negedge clk);

        for (int i = 0; i < 13; i++) begin
            sb_q.push_back('{vecs[i].digit, vecs[i].den, vecs[i].ien, vecs[i].err});
            send_bits(vecs[i].bits, vecs[i].n);
            count_err(errs);
            if (sb_q.size() == 0) begin
                check($sformatf("v%0d_scoreboard", i), 32'd0, 32'd1);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("v%0d_digit", i), 32'(digit_a), 32'(e.digit));
                check($sformatf("v%0d_digitEn", i), 32'(den_a), 32'(e.den));
                check($sformatf("v%0d_instrEn", i), 32'(ien_a), 32'(e.ien));
                check($sformatf("v%0d_errPulses", i), 32'(errs), e.err ? 32'd1 : 32'd0);
            end
        end

        // Hold timer on dut_b: digitEn lasts exactly 100 cycles after the commit.
        send_bits(16'h0003, 8);
        waited = 0;
        @(negedge clk);
        while (den_b !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("hold_commit_seen", 32'(den_b), 32'd1);
        stay_ok = 1'b1;
        repeat (99) begin
            @(negedge clk);
            if (den_b !== 1'b1 || ien_b !== 1'b0) stay_ok = 1'b0;
        end
        check("hold_stays_99", 32'(stay_ok), 32'd1);
        @(negedge clk);
        check("hold_expire_digitEn", 32'(den_b), 32'd0);
        check("hold_expire_instrEn", 32'(ien_b), 32'd1);
        check("hold_expire_digit", 32'(digit_b), 32'd3);
        check("nohold_digitEn", 32'(den_a), 32'd1);
        check("nohold_digit", 32'(digit_a), 32'd3);

        // Reset in the middle of frame 0x05; the tail of the frame must not commit.
        @(negedge clk);
        csN = 1'b0;
        repeat (8) @(negedge clk);
        sck_bit(1'b0);
        sck_bit(1'b0);
        sck_bit(1'b0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("midrst_digit", 32'(digit_a), 32'd0);
        check("midrst_digitEn", 32'(den_a), 32'd0);
        check("midrst_instrEn", 32'(ien_a), 32'd1);
        reset = 1'b1;
        sck_bit(1'b0);
        sck_bit(1'b0);
        sck_bit(1'b1);
        sck_bit(1'b0);
        sck_bit(1'b1);
        repeat (6) @(negedge clk);
        csN = 1'b1;
        count_err(errs);
        check("midrst_errPulses", 32'(errs), 32'd0);
        check("midrst_after_digit", 32'(digit_a), 32'd0);
        check("midrst_after_digitEn", 32'(den_a), 32'd0);
        check("midrst_after_instrEn", 32'(ien_a), 32'd1);

`ifdef SPI_ECHO_EN
        send_bits(16'h0005, 8);
        count_err(errs);
        echo_cap = '0;
        send_bits(16'h0040, 8);
        count_err(errs);
        check("echo_byte", 32'(echo_cap[7:0]), 32'h05);
        check("echo_frame_instrEn", 32'(ien_a), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_digit_ctrl.md
Name: spi_digit_ctrl

Overview:
- SPI-slave command receiver directly upstream of the VGA digit display.
- Takes 8-bit command frames from the rail-control microcontroller and decodes them.
- Drives the registered digit, digitEn and instrEn inputs that the display's video generator consumes.
- Enforces a display-hold timeout and flags malformed frames.

Parameters:
- SYNC_STAGES, 2: flops in each input synchronizer (sck, sdi, csN); legal values are 2 or 3.
- HOLD_CYCLES, 32'd400_000_000: clk cycles an accepted digit stays displayed before reverting to instructions; 0 disables the timeout.
- HOLD_W, 32: width of the hold counter.

Ports:
- clk, input, 1: system clock (40 MHz board clock; same clock that drives the video generator).
- reset, input, 1: one clock; reset is synchronous and active-low (reset==0 resets on a rising clk edge).
- sck, input, 1: SPI clock, asynchronous, mode 0, ≤ clk/8.
- sdi, input, 1: SPI data in, MSB first, sampled on sck rise.
- csN, input, 1: SPI chip select, active-low, asynchronous.
- digit, output, 4: digit to display, 0..9.
- digitEn, output, 1: digit rendering enable.
- instrEn, output, 1: instruction-text mode.
- cmdErr, output, 1: one-cycle pulse when a frame is rejected.

Behaviour:
- Reset values: digit=0, digitEn=0, instrEn=1, cmdErr=0, FSM=IDLE, bitCnt=0, hold counter=0.
- Synchronization: sck, sdi and csN each pass through SYNC_STAGES flops. One extra flop per signal gives edge detection (sckRise, csFall, csRise). No other logic uses the raw pins.
- FSM states:
  - IDLE: csFall → SHIFT, clear shiftReg and bitCnt.
  - SHIFT: on each sckRise, shiftReg <= {shiftReg[6:0], sdi}; bitCnt saturates at 9. On csRise → CHECK.
  - CHECK (1 cycle): bitCnt==8 → decode, else reject. Always → IDLE.
- Opcode = byte[7:6]:
  - 00 SET_DIGIT: byte[3:0] ≤ 9 → digit <= byte[3:0], digitEn=1, instrEn=0, hold counter loaded with HOLD_CYCLES. byte[3:0] > 9 → reject, outputs unchanged. byte[5:4] ignored.
  - 01 SHOW_INSTR: instrEn=1, digitEn=0, digit unchanged, hold counter cleared.
  - 10 BLANK: digitEn=0, instrEn=0, hold counter cleared.
  - 11 reserved: reject.
- Reject: cmdErr=1 for exactly one cycle (the cycle after CHECK); outputs unchanged.
- Short frame (<8 bits) or overrun (>8 bits): reject.
- csRise with no sckRise at all: reject.
- Latency: csN rising at the pin → outputs updated on clk edge number SYNC_STAGES+3 after the first sync flop samples 1.
- Hold timer: decrements while nonzero. On the 1→0 transition, instrEn=1 and digitEn=0; digit is held.
  - HOLD_CYCLES==0: counter never loads, so there is no timeout.
  - A commit in the same cycle the counter reaches 0: the commit wins (SET_DIGIT reloads; others apply their own values).
- Outputs are registered and change only at commit or timeout. No glitches toward the display.
- A reset (reset==0) mid-frame returns the block to reset values. The remaining bits of that frame are discarded because the FSM waits in IDLE for a fresh csFall.
- csFall while in SHIFT (csN glitch after csRise was missed) is impossible after synchronization; csFall is only decoded in IDLE.

Optional Feature:
- Macro SPI_ECHO_EN.
- Defined:
  - Adds output sdo (1 bit).
  - On csFall, a tx shift register loads the last accepted command byte (0x40 after reset).
  - sdo is driven from the synchronized-sck falling-edge detect, MSB first, so the MCU can read back state.
  - Rejected frames do not update the echo byte.
- Not defined: no sdo port and no tx register; behaviour is otherwise identical.

Decomposition:
- Package spi_digit_pkg:
  - opcode_t enum: OP_SET_DIGIT=2'b00, OP_SHOW_INSTR=2'b01, OP_BLANK=2'b10, OP_RSVD=2'b11.
  - state_t enum: IDLE, SHIFT, CHECK.
  - localparams FRAME_BITS=8, MAX_DIGIT=4'd9, RESET_ECHO=8'h40.
- Sub-module spi_sync_edge (parameter SYNC_STAGES): one instance per input, outputs level, rise and fall.
- FSM, decode and hold timer stay in spi_digit_ctrl.

Test Plan:
- Reset, then frame 0x07 → digit=7, digitEn=1, instrEn=0, cmdErr never pulses.
- Frame 0x0C (digit 12) after 0x07 → cmdErr pulses 1 cycle; digit stays 7, digitEn stays 1.
- HOLD_CYCLES=100, frame 0x03 → after exactly 100 cycles, instrEn=1, digitEn=0, digit=3.
- A 5-bit frame, then csN high → cmdErr pulse, outputs unchanged. A 9-bit frame behaves the same.
- Frame 0x80 (BLANK) then 0x40 (SHOW_INSTR) → {digitEn,instrEn} goes 00 then 01. Reset asserted mid-frame of 0x05 → reset values, and the partial frame does not commit.
- With SPI_ECHO_EN: frame 0x05, then frame 0x40 → sdo shifts out 0x05 during the second frame.
